// File: rtl/gelato_warp_scheduler.sv
// Round-robin warp issue scheduler: picks one eligible warp per cycle, pops its
// instruction buffer and holds the instruction in a valid/ready output register.

module gelato_warp_elig (
    input  logic active_i,
    input  logic stall_i,
    input  logic empty_i,
    input  logic popped_i,
    output logic elig_o
);
    assign elig_o = active_i & ~stall_i & ~empty_i & ~popped_i;
endmodule

module gelato_warp_scheduler #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_ID_W = $clog2(NUM_WARPS),
    parameter int INST_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rdy_i,
    input  logic                        flush_i,
    input  logic [NUM_WARPS-1:0]        warp_active_i,
    input  logic [NUM_WARPS-1:0]        warp_stall_i,
    input  logic [NUM_WARPS-1:0]        buf_empty_i,
    input  logic [NUM_WARPS*INST_W-1:0] buf_tail_data_i,
    output logic [NUM_WARPS-1:0]        buf_pop_o,
    output logic                        issue_valid_o,
    output logic [WARP_ID_W-1:0]        issue_warp_id_o,
    output logic [INST_W-1:0]           issue_inst_o,
    input  logic                        issue_ready_i
);
    typedef struct packed {
        logic [WARP_ID_W-1:0] wid;
        logic [INST_W-1:0]    inst;
    } issue_t;

    issue_t               issue_q, issue_d;
    logic                 valid_q, valid_d;
    logic [WARP_ID_W-1:0] rr_q, rr_d;
    logic [NUM_WARPS-1:0] popped_q, popped_d;

    logic [NUM_WARPS-1:0] elig;
    logic [WARP_ID_W-1:0] win;
    logic                 found;
    logic                 slot_free;
    logic                 grant;
    logic [NUM_WARPS-1:0] pop_vec;

    // popped_q masks the previous winner while its buffer updates empty/tail
    gelato_warp_elig u_elig [NUM_WARPS-1:0] (
        .active_i (warp_active_i),
        .stall_i  (warp_stall_i),
        .empty_i  (buf_empty_i),
        .popped_i (popped_q),
        .elig_o   (elig)
    );

    // Scan rr_q+1 .. rr_q+NUM_WARPS; the truncated add gives the modulo wrap
    always_comb begin
        logic [WARP_ID_W-1:0] idx;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = rr_q + WARP_ID_W'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign slot_free = !valid_q || issue_ready_i;
    assign grant     = rdy_i && !flush_i && slot_free && found;
    assign pop_vec   = grant ? (NUM_WARPS'(1) << win) : '0;
    assign buf_pop_o = rst_n ? pop_vec : '0;

    always_comb begin
        issue_d  = issue_q;
        valid_d  = valid_q;
        rr_d     = rr_q;
        popped_d = popped_q;
        if (rdy_i) begin
            if (flush_i) begin
                valid_d  = 1'b0;
                popped_d = '0;
            end else if (grant) begin
                issue_d.wid  = win;
                issue_d.inst = buf_tail_data_i[win*INST_W +: INST_W];
                valid_d      = 1'b1;
                rr_d         = win;
                popped_d     = pop_vec;
            end else begin
                popped_d = '0;
                if (valid_q && issue_ready_i) valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q  <= '0;
            valid_q  <= 1'b0;
            rr_q     <= WARP_ID_W'(NUM_WARPS - 1);
            popped_q <= '0;
        end else begin
            issue_q  <= issue_d;
            valid_q  <= valid_d;
            rr_q     <= rr_d;
            popped_q <= popped_d;
        end
    end

    assign issue_valid_o   = valid_q;
    assign issue_warp_id_o = issue_q.wid;
    assign issue_inst_o    = issue_q.inst;
endmodule

// File: doc/gelato_warp_scheduler.md
Name: gelato_warp_scheduler

Overview:
- Issue scheduler between the per-warp instruction buffers and the issue/operand stage.
- Each cycle it picks one eligible warp round-robin, pops that warp's buffer and holds the instruction in a single output register.
- The output register uses a valid/ready handshake to the downstream stage.
- Warps are masked by scoreboard/barrier stall inputs and by an active-warp mask.

Parameters:
NUM_WARPS, 4, number of warp instruction buffers arbitrated (power of two, >=2)
WARP_ID_W, $clog2(NUM_WARPS), width of the warp index
INST_W, 32, width of a packed decoded instruction (inst_t)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
rdy  input  1  global enable; when low all state holds and no pop is issued
flush  input  1  synchronous discard of the held instruction
warp_active  input  NUM_WARPS  warp w may be scheduled when bit w=1
warp_stall  input  NUM_WARPS  scoreboard/barrier stall; bit w=1 blocks warp w
buf_empty  input  NUM_WARPS  per-warp buffer empty flag
buf_tail_data  input  NUM_WARPS*INST_W  per-warp head instruction; warp w at bits [w*INST_W +: INST_W]
buf_pop  output  NUM_WARPS  one-hot pop pulse to the granted warp's buffer
issue_valid  output  1  held instruction is valid
issue_warp_id  output  WARP_ID_W  warp index of the held instruction
issue_inst  output  INST_W  held instruction
issue_ready  input  1  downstream accepts when issue_valid && issue_ready

Behaviour:
- Reset values (async, rst_n low):
  - issue_valid=0, issue_warp_id=0, issue_inst=0.
  - Round-robin pointer rr_ptr=NUM_WARPS-1, so warp 0 has first priority.
  - popped_last mask = 0.
  - buf_pop is combinational and reads 0 while in reset.
- Eligibility of warp w: warp_active[w] && !warp_stall[w] && !buf_empty[w] && !popped_last[w].
- popped_last[w] is set in the cycle after warp w is popped and cleared after one cycle. This covers the buffer's one-cycle empty/tail update latency, so a warp cannot issue back-to-back.
- slot_free = !issue_valid || issue_ready.
- Grant:
  - Computed only when rdy && !flush && slot_free && any warp is eligible.
  - Winner is the first eligible warp scanning rr_ptr+1, rr_ptr+2, ... with modulo NUM_WARPS wrap-around.
- buf_pop, combinational:
  - One-hot of the winner when a grant occurs, else all zeros.
  - Never more than one bit set. Never asserted when rdy=0.
- On a grant, at the posedge:
  - issue_inst <= buf_tail_data[winner].
  - issue_warp_id <= winner.
  - issue_valid <= 1.
  - rr_ptr <= winner.
  - popped_last <= one-hot(winner).
- Latency: instruction appears on issue_* one cycle after its buf_pop pulse.
- Throughput: one issue per cycle when at least two warps alternate. A single warp issues every other cycle because of popped_last.
- Accept without grant: issue_valid && issue_ready and no eligible warp -> issue_valid <= 0.
- Backpressure: issue_valid && !issue_ready -> issue_* hold stable, no pop, rr_ptr unchanged.
- Stall/active bits are sampled combinationally in the grant cycle. A stall rising after capture does not revoke the held instruction.
- flush (when rdy):
  - issue_valid <= 0 and no grant that cycle.
  - rr_ptr holds; popped_last <= 0.
  - The popped instruction held in the output register is discarded. Replay is the front-end's responsibility.
- rdy=0: every register holds, including popped_last. issue_valid stays as is; issue_ready is ignored.
- Reset mid-operation: the held instruction is dropped and state returns to reset values. Buffer contents are not touched.
- Arithmetic: rr_ptr and the scan index wrap modulo NUM_WARPS; the scan is purely combinational with no wide adders.

Test Plan:
- Reset then all four warps non-empty, active, unstalled, issue_ready=1:
  - buf_pop sequence 0001,0010,0100,1000,0001.
  - issue_warp_id 0,1,2,3,0, each one cycle after its pop.
- Only warp 2 non-empty with issue_ready=1:
  - buf_pop=0100 on alternate cycles only.
  - issue_valid toggles 1,0,1,0.
- Grant warp 1 (inst 0xDEADBEEF), then issue_ready=0 for 3 cycles:
  - issue_inst stays 0xDEADBEEF and issue_warp_id=1.
  - buf_pop=0 throughout.
  - After release, the next grant is warp 2.
- warp_stall=0101 and warp_active=1110 with all warps non-empty: only warps 1 and 3 are granted, alternating 1,3,1,3.
- flush asserted while issue_valid=1: the next cycle has issue_valid=0 and no pop in the flush cycle; then round-robin resumes from rr_ptr+1.
- rdy=0 for 2 cycles mid-stream:
  - buf_pop=0 and all outputs frozen.
  - Sequence continues unchanged after rdy returns.
  - An async rst_n pulse mid-stream forces issue_valid=0 immediately.
